vga_sync_ctrl: RTL and testbench
================================

# vga_sync_ctrl

- Runs entirely in the CLK50 domain and sequences the VGA raster for the Tetris display.
- Replaces the divided 25 MHz clock with a single-cycle pixel enable (PIX_EN) and drives the horizontal/vertical counters, sync pulses, visible-area flag, pixel coordinates and a frame-start strobe.
- Sits between the board oscillator and the pixel/colour generator.
- Downstream logic qualifies all updates with PIX_EN instead of clocking on a derived clock.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports (one clock; reset is asynchronous and active-high):
- CLK50  input  1  50 MHz system clock; all state on its rising edge
- RST  input  1  asynchronous, active-high reset
- PIX_EN  output  1  pixel enable, high every second CLK50 cycle
- HSYNC  output  1  horizontal sync, active low
- VSYNC  output  1  vertical sync, active low
- VIDEO_ON  output  1  high while PIX_X/PIX_Y are inside the visible area
- PIX_X  output  10  current pixel column
- PIX_Y  output  10  current pixel row
- FRAME_START  output  1  one-CLK50-cycle strobe at frame wrap
- FRAME_CNT  output  8  frame counter (see Configuration)

## Operation
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤ 1024.
- **Pixel enable:** internal toggle flop, reset 0, inverts every CLK50 edge. PIX_EN is that flop, so PIX_EN = 1 on alternate cycles.
- **Counters:** H and V are 10-bit and advance only on edges where PIX_EN = 1.
  - H counts 0..H_TOTAL-1, then wraps to 0.
  - V increments when H wraps and counts 0..V_TOTAL-1, then wraps to 0.
  - Increments are unsigned and never exceed the total.
- **Registered decode:** on each PIX_EN edge, the output registers load from the current (pre-increment) H and V:
  - PIX_X ← H; PIX_Y ← V.
  - VIDEO_ON ← (H < H_VISIBLE) && (V < V_VISIBLE).
  - HSYNC ← !(H ≥ H_VISIBLE+H_FRONT && H < H_VISIBLE+H_FRONT+H_SYNC).
  - VSYNC ← !(V ≥ V_VISIBLE+V_FRONT && V < V_VISIBLE+V_FRONT+V_SYNC).
- **FRAME_START:** registered. Set to 1 on the PIX_EN edge where H = H_TOTAL-1 and V = V_TOTAL-1; cleared on the next CLK50 edge, so it is exactly one CLK50 cycle wide.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronously). No FRAME_START is emitted for the aborted frame. Counting restarts at (0,0).

## Timing
- Reset values: PIX_EN = 0, H = 0, V = 0, PIX_X = 0, PIX_Y = 0, HSYNC = 1, VSYNC = 1, VIDEO_ON = 0, FRAME_START = 0, FRAME_CNT = 0.
- PIX_EN is 1 after the 1st, 3rd, 5th, … CLK50 edges following RST deassertion.
- First PIX_EN edge (2nd edge after release): outputs show pixel (0,0) with VIDEO_ON = 1. Counter-to-output latency is one pixel (2 CLK50 cycles).
- All outputs change only on edges where PIX_EN = 1, except FRAME_START, which falls on the following edge.
- Line period: 1600 CLK50 cycles. Frame period: 840 000 CLK50 cycles.
- HSYNC low for PIX_X 656..751. VSYNC low for PIX_Y 490..491.

## Configuration
- Macro: VGA_FRAME_CNT_EN.
- Defined: FRAME_CNT is an 8-bit register, reset 0. It increments on the same edge that sets FRAME_START and wraps 255 → 0. The game logic uses it for drop pacing.
- Undefined: no register is built and FRAME_CNT is tied to 8'd0. All other behaviour is identical.

## Test plan
- **Reset values:** hold RST = 1 for 5 cycles → every output at its reset value; release → PIX_EN pattern 1,0,1,0 from the 1st edge.
- **First pixel:** run to the 2nd post-reset edge → PIX_X = 0, PIX_Y = 0, VIDEO_ON = 1, HSYNC = 1, VSYNC = 1.
- **Horizontal line:** run one line → HSYNC low exactly while PIX_X = 656..751 (192 CLK50 cycles); VIDEO_ON falls when PIX_X = 640; PIX_Y increments after PIX_X = 799.
- **Frame:** run two frames → FRAME_START pulses exactly 840 000 cycles apart, each 1 cycle wide; VSYNC low only for PIX_Y = 490..491 (3200 cycles).
- **Mid-frame reset:** assert RST at PIX_Y = 300 → outputs reset asynchronously with no FRAME_START; after release, the first FRAME_START occurs at post-release cycle 840 000 ± 1.
- **Frame counter:** with VGA_FRAME_CNT_EN, run 256 frames → FRAME_CNT counts 1..255 then 0. Without the macro → FRAME_CNT stays 0.

Source files
------------

// File: rtl/vga_sync_ctrl.sv
// VGA raster sequencer in the CLK50 domain: pixel enable, H/V counters, registered sync/visible decode.
// Optional frame counter is built only when VGA_FRAME_CNT_EN is defined; otherwise FRAME_CNT is tied to zero.
module vga_sync_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLK50,
    input  logic       RST,
    output logic       PIX_EN,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VIDEO_ON,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       FRAME_START,
    output logic [7:0] FRAME_CNT
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_S = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_E = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_S = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_E = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    function automatic logic in_band(input logic [9:0] c, input logic [9:0] lo, input logic [9:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

    logic [9:0] h_p0;
    logic [9:0] v_p0;
    logic       h_wrap;
    logic       v_wrap;

    assign h_wrap = (h_p0 == H_MAX);
    assign v_wrap = (v_p0 == V_MAX);

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            PIX_EN      <= 1'b0;
            h_p0        <= '0;
            v_p0        <= '0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            VIDEO_ON    <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            PIX_EN      <= ~PIX_EN;
            // Strobe rises on the last pixel's enable edge and drops on the following (non-enable) edge.
            FRAME_START <= PIX_EN && h_wrap && v_wrap;
            if (PIX_EN) begin
                // Stage p0: raster counters.
                h_p0 <= h_wrap ? '0 : h_p0 + 10'd1;
                if (h_wrap)
                    v_p0 <= v_wrap ? '0 : v_p0 + 10'd1;
                // Stage p1: decode of the pre-increment position.
                PIX_X    <= h_p0;
                PIX_Y    <= v_p0;
                VIDEO_ON <= (h_p0 < H_VIS) && (v_p0 < V_VIS);
                HSYNC    <= !in_band(h_p0, H_SYNC_S, H_SYNC_E);
                VSYNC    <= !in_band(v_p0, V_SYNC_S, V_SYNC_E);
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST)
            FRAME_CNT <= 8'd0;
        else if (PIX_EN && h_wrap && v_wrap)
            FRAME_CNT <= FRAME_CNT + 8'd1;
    end
`else
    assign FRAME_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench for vga_sync_ctrl using a shrunken raster (15 x 8 pixels, 240 CLK50 cycles per frame).
module tb_vga_sync_ctrl;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CYC = 2 * HT * VT;

    logic       CLK50 = 1'b0;
    logic       RST   = 1'b1;
    logic       PIX_EN, HSYNC, VSYNC, VIDEO_ON, FRAME_START;
    logic [9:0] PIX_X, PIX_Y;
    logic [7:0] FRAME_CNT;

    int checks = 0;
    int errors = 0;

    vga_sync_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .CLK50(CLK50), .RST(RST), .PIX_EN(PIX_EN), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .VIDEO_ON(VIDEO_ON), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
        .FRAME_START(FRAME_START), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK50 = ~CLK50;

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n, idx, x, y, hs_low, vs_low, fs_first, fs_second, wait_n;
        bit found;

        // Reset held for 5 cycles
        repeat (5) tick();
        chk("rst_pix_en", 32'(PIX_EN), 0);
        chk("rst_pix_x", 32'(PIX_X), 0);
        chk("rst_pix_y", 32'(PIX_Y), 0);
        chk("rst_hsync", 32'(HSYNC), 1);
        chk("rst_vsync", 32'(VSYNC), 1);
        chk("rst_video_on", 32'(VIDEO_ON), 0);
        chk("rst_frame_start", 32'(FRAME_START), 0);
        chk("rst_frame_cnt", 32'(FRAME_CNT), 0);

        // Release; first edges after release
        RST = 1'b0;
        tick();
        chk("e1_pix_en", 32'(PIX_EN), 1);
        chk("e1_video_on", 32'(VIDEO_ON), 0);
        tick();
        chk("e2_pix_en", 32'(PIX_EN), 0);
        chk("e2_pix_x", 32'(PIX_X), 0);
        chk("e2_pix_y", 32'(PIX_Y), 0);
        chk("e2_video_on", 32'(VIDEO_ON), 1);
        chk("e2_hsync", 32'(HSYNC), 1);
        chk("e2_vsync", 32'(VSYNC), 1);
        tick();
        chk("e3_pix_en", 32'(PIX_EN), 1);
        chk("e3_pix_x", 32'(PIX_X), 0);
        tick();
        chk("e4_pix_en", 32'(PIX_EN), 0);
        chk("e4_pix_x", 32'(PIX_X), 1);

        // Two full frames against the raster definition
        hs_low = 0; vs_low = 0; fs_first = -1; fs_second = -1;
        for (n = 5; n <= 2 * FRAME_CYC + 20; n++) begin
            tick();
            idx = n / 2 - 1;
            x = idx % HT;
            y = (idx / HT) % VT;
            chk("run_pix_en", 32'(PIX_EN), 32'(n % 2));
            chk("run_pix_x", 32'(PIX_X), 32'(x));
            chk("run_pix_y", 32'(PIX_Y), 32'(y));
            chk("run_video_on", 32'(VIDEO_ON), 32'((x < HV) && (y < VV)));
            chk("run_hsync", 32'(HSYNC), 32'(!(x >= 10 && x <= 12)));
            chk("run_vsync", 32'(VSYNC), 32'(!(y >= 5 && y <= 6)));
            chk("run_frame_start", 32'(FRAME_START), 32'(n % FRAME_CYC == 0));
`ifdef VGA_FRAME_CNT_EN
            chk("run_frame_cnt", 32'(FRAME_CNT), 32'((n / FRAME_CYC) % 256));
`else
            chk("run_frame_cnt", 32'(FRAME_CNT), 0);
`endif
            if (n <= 31 && !HSYNC) hs_low++;
            if (n <= FRAME_CYC && !VSYNC) vs_low++;
            if (FRAME_START) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (n == 20) begin
                chk("x9_pix_x", 32'(PIX_X), 9);
                chk("x9_hsync", 32'(HSYNC), 1);
            end
            if (n == 22) begin
                chk("x10_pix_x", 32'(PIX_X), 10);
                chk("x10_hsync", 32'(HSYNC), 0);
            end
            if (n == 18) chk("x8_video_on", 32'(VIDEO_ON), 0);
            if (n == 32) begin
                chk("line2_pix_x", 32'(PIX_X), 0);
                chk("line2_pix_y", 32'(PIX_Y), 1);
            end
        end
        chk("line_hsync_low_cycles", 32'(hs_low), 6);
        chk("frame_vsync_low_cycles", 32'(vs_low), 60);
        chk("first_frame_start_edge", 32'(fs_first), 32'(FRAME_CYC));
        chk("frame_start_period", 32'(fs_second - fs_first), 32'(FRAME_CYC));

        // Mid-frame asynchronous reset at PIX_Y = 2
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (PIX_Y == 10'd2 && PIX_EN == 1'b0) found = 1;
        end
        chk("wait_row2", 32'(found), 1);
        #2 RST = 1'b1;
        #1;
        chk("async_pix_en", 32'(PIX_EN), 0);
        chk("async_pix_x", 32'(PIX_X), 0);
        chk("async_pix_y", 32'(PIX_Y), 0);
        chk("async_hsync", 32'(HSYNC), 1);
        chk("async_vsync", 32'(VSYNC), 1);
        chk("async_video_on", 32'(VIDEO_ON), 0);
        repeat (3) begin
            tick();
            chk("rst_hold_frame_start", 32'(FRAME_START), 0);
        end
        RST = 1'b0;
        wait_n = 0;
        found = 0;
        while (!found && wait_n < 4 * FRAME_CYC) begin
            tick();
            wait_n++;
            if (FRAME_START) found = 1;
        end
        chk("post_reset_frame_start_found", 32'(found), 1);
        chk("post_reset_frame_start_edge", 32'(wait_n), 32'(FRAME_CYC));
        tick();
        chk("frame_start_width", 32'(FRAME_START), 0);

`ifdef VGA_FRAME_CNT_EN
        chk("fcnt_after_reset_frame", 32'(FRAME_CNT), 1);
        for (int f = 2; f <= 256; f++) begin
            wait_n = 0;
            found = 0;
            while (!found && wait_n < 2 * FRAME_CYC) begin
                tick();
                wait_n++;
                if (FRAME_START) found = 1;
            end
            chk("fcnt_frame_found", 32'(found), 1);
            chk("fcnt_value", 32'(FRAME_CNT), 32'(f % 256));
        end
`else
        chk("fcnt_tied_zero", 32'(FRAME_CNT), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
